// File: rtl/motion_seq.sv
// Control-cycle sequencer: two A2D conversions, then a fixed series of passes
// through an external ALU that produce the PI terms and the motor drive values.
module motion_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] a2d_res,
  input  logic [15:0] dst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] accum,
  output logic [15:0] pcomp,
  output logic [11:0] error,
  output logic [11:0] intgrl,
  output logic [11:0] icomp,
  output logic [11:0] iterm,
  output logic [13:0] pterm,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, CNV_A, WAIT_A, CNV_B, WAIT_B, ERR, INTG, ICMP1, ICMP2,
    PCMP1, PCMP2, RHT1, RHT2, LFT1, LFT2
  } state_t;

  localparam logic [2:0] SRC1_ACCUM  = 3'd0;
  localparam logic [2:0] SRC1_ITERM  = 3'd1;
  localparam logic [2:0] SRC1_ERROR  = 3'd2;
  localparam logic [2:0] SRC1_FWD    = 3'd4;
  localparam logic [2:0] SRC0_A2D    = 3'd0;
  localparam logic [2:0] SRC0_INTGRL = 3'd1;
  localparam logic [2:0] SRC0_ICOMP  = 3'd2;
  localparam logic [2:0] SRC0_PCOMP  = 3'd3;
  localparam logic [2:0] SRC0_PTERM  = 3'd4;

  state_t      r_state, w_nxt;
  logic        r_strt_cnv, r_done;
  logic [2:0]  r_chnnl;
  logic [1:0]  r_int_dec;
  logic [15:0] r_accum, r_pcomp;
  logic [11:0] r_error, r_intgrl, r_icomp, r_lft, r_rht;

  logic        w_strt, w_done;
  logic [2:0]  w_chnnl;
  logic        w_ld_accum_a, w_ld_accum_dst, w_ld_err, w_ld_intg;
  logic        w_ld_icomp, w_ld_pcomp, w_ld_rht, w_ld_lft;

  assign iterm    = 12'h500;
  assign pterm    = 14'h3680;
  assign strt_cnv = r_strt_cnv;
  assign done     = r_done;
  assign chnnl    = r_chnnl;
  assign accum    = r_accum;
  assign pcomp    = r_pcomp;
  assign error    = r_error;
  assign intgrl   = r_intgrl;
  assign icomp    = r_icomp;
  assign lft      = r_lft;
  assign rht      = r_rht;

  // Multiplies take two cycles through the ALU, so ICMP/PCMP hold their
  // selects for both states and only capture dst on the second.
  always_comb begin
    w_nxt          = r_state;
    src0sel        = 3'd0;
    src1sel        = 3'd0;
    multiply       = 1'b0;
    sub            = 1'b0;
    mult2          = 1'b0;
    mult4          = 1'b0;
    saturate       = 1'b0;
    w_strt         = 1'b0;
    w_chnnl        = 3'd0;
    w_done         = 1'b0;
    w_ld_accum_a   = 1'b0;
    w_ld_accum_dst = 1'b0;
    w_ld_err       = 1'b0;
    w_ld_intg      = 1'b0;
    w_ld_icomp     = 1'b0;
    w_ld_pcomp     = 1'b0;
    w_ld_rht       = 1'b0;
    w_ld_lft       = 1'b0;
    case (r_state)
      IDLE: if (go) begin
        w_nxt   = CNV_A;
        w_strt  = 1'b1;
        w_chnnl = 3'd0;
      end
      CNV_A: w_nxt = WAIT_A;
      WAIT_A: if (cnv_cmplt) begin
        w_nxt        = CNV_B;
        w_ld_accum_a = 1'b1;
        w_strt       = 1'b1;
        w_chnnl      = 3'd1;
      end
      CNV_B: w_nxt = WAIT_B;
      WAIT_B: if (cnv_cmplt) w_nxt = ERR;
      ERR: begin
        src1sel = SRC1_ACCUM; src0sel = SRC0_A2D;
        sub = 1'b1; saturate = 1'b1; w_ld_err = 1'b1;
        w_nxt = INTG;
      end
      INTG: begin
        src1sel = SRC1_ERROR; src0sel = SRC0_INTGRL; saturate = 1'b1;
        w_ld_intg = (r_int_dec == 2'b11);
        w_nxt = ICMP1;
      end
      ICMP1, ICMP2: begin
        src1sel = SRC1_ITERM; src0sel = SRC0_INTGRL; multiply = 1'b1;
        w_ld_icomp = (r_state == ICMP2);
        w_nxt = (r_state == ICMP1) ? ICMP2 : PCMP1;
      end
      PCMP1, PCMP2: begin
        src1sel = SRC1_ERROR; src0sel = SRC0_PTERM; multiply = 1'b1;
        w_ld_pcomp = (r_state == PCMP2);
        w_nxt = (r_state == PCMP1) ? PCMP2 : RHT1;
      end
      RHT1: begin
        src1sel = SRC1_FWD; src0sel = SRC0_PCOMP; sub = 1'b1;
        w_ld_accum_dst = 1'b1; w_nxt = RHT2;
      end
      RHT2: begin
        src1sel = SRC1_ACCUM; src0sel = SRC0_ICOMP; sub = 1'b1; saturate = 1'b1;
        w_ld_rht = 1'b1; w_nxt = LFT1;
      end
      LFT1: begin
        src1sel = SRC1_FWD; src0sel = SRC0_PCOMP;
        w_ld_accum_dst = 1'b1; w_nxt = LFT2;
      end
      LFT2: begin
        src1sel = SRC1_ACCUM; src0sel = SRC0_ICOMP; saturate = 1'b1;
        w_ld_lft = 1'b1; w_done = 1'b1; w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_strt_cnv <= 1'b0;
      r_done     <= 1'b0;
      r_chnnl    <= 3'd0;
      r_int_dec  <= 2'd0;
      r_accum    <= 16'd0;
      r_pcomp    <= 16'd0;
      r_error    <= 12'd0;
      r_intgrl   <= 12'd0;
      r_icomp    <= 12'd0;
      r_lft      <= 12'd0;
      r_rht      <= 12'd0;
    end else begin
      r_state    <= w_nxt;
      r_strt_cnv <= w_strt;
      r_done     <= w_done;
      if (w_strt)         r_chnnl   <= w_chnnl;
      if (w_done)         r_int_dec <= r_int_dec + 2'd1;
      if (w_ld_accum_a)   r_accum   <= {4'h0, a2d_res};
      else if (w_ld_accum_dst) r_accum <= dst;
      if (w_ld_err)       r_error   <= dst[11:0];
      if (w_ld_intg)      r_intgrl  <= dst[11:0];
      if (w_ld_icomp)     r_icomp   <= dst[11:0];
      if (w_ld_pcomp)     r_pcomp   <= dst;
      if (w_ld_rht)       r_rht     <= dst[11:0];
      if (w_ld_lft)       r_lft     <= dst[11:0];
    end
  end

endmodule

// File: tb/tb_motion_seq.sv
// Bench for motion_seq: a behavioural ALU closes the loop on dst, and each
// control cycle's results are predicted from plain arithmetic on A, B and fwd.
module tb_motion_seq;

  logic        clk, rst_n, go, cnv_cmplt;
  logic [11:0] a2d_res;
  logic [15:0] dst;
  logic        strt_cnv, multiply, sub, mult2, mult4, saturate, done;
  logic [2:0]  chnnl, src0sel, src1sel;
  logic [15:0] accum, pcomp;
  logic [11:0] error, intgrl, icomp, iterm, lft, rht;
  logic [13:0] pterm;

  logic signed [15:0] fwd;
  logic signed [15:0] alu_s1, alu_s0;
  logic signed [16:0] alu_sum;
  logic signed [31:0] alu_prod;

  int n_cmp = 0, n_fail = 0, n_strt = 0, n_bad = 0;
  int m_int_dec = 0, m_intgrl = 0;

  motion_seq dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cnv_cmplt(cnv_cmplt), .a2d_res(a2d_res),
    .dst(dst), .strt_cnv(strt_cnv), .chnnl(chnnl), .src0sel(src0sel),
    .src1sel(src1sel), .multiply(multiply), .sub(sub), .mult2(mult2),
    .mult4(mult4), .saturate(saturate), .accum(accum), .pcomp(pcomp),
    .error(error), .intgrl(intgrl), .icomp(icomp), .iterm(iterm),
    .pterm(pterm), .lft(lft), .rht(rht), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: A2D_RES is sign-extended on src0, so 0x000 - 0xFFF gives 0x001.
  always_comb begin
    alu_s1 = '0;
    alu_s0 = '0;
    case (src1sel)
      3'd0: alu_s1 = accum;
      3'd1: alu_s1 = {4'h0, iterm};
      3'd2: alu_s1 = {{4{error[11]}}, error};
      3'd4: alu_s1 = fwd;
      default: alu_s1 = '0;
    endcase
    case (src0sel)
      3'd0: alu_s0 = {{4{a2d_res[11]}}, a2d_res};
      3'd1: alu_s0 = {{4{intgrl[11]}}, intgrl};
      3'd2: alu_s0 = {{4{icomp[11]}}, icomp};
      3'd3: alu_s0 = pcomp;
      3'd4: alu_s0 = {2'b00, pterm};
      default: alu_s0 = '0;
    endcase
    alu_sum  = sub ? (17'(alu_s1) - 17'(alu_s0)) : (17'(alu_s1) + 17'(alu_s0));
    alu_prod = 32'(alu_s1) * 32'(alu_s0);
    if (multiply)                             dst = alu_prod[27:12];
    else if (saturate && alu_sum > 17'sd2047)  dst = 16'h07FF;
    else if (saturate && alu_sum < -17'sd2048) dst = 16'hF800;
    else                                      dst = alu_sum[15:0];
  end

  always @(posedge clk) begin
    if (strt_cnv === 1'b1) n_strt <= n_strt + 1;
    if (mult2 !== 1'b0 || mult4 !== 1'b0) n_bad <= n_bad + 1;
  end

  function automatic int sat12(input int x);
    return (x > 2047) ? 2047 : ((x < -2048) ? -2048 : x);
  endfunction

  function automatic int sx12(input logic [11:0] v);
    logic signed [11:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int w16(input int x);
    logic signed [15:0] t;
    t = 16'(x);
    return int'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".strt"},   32'(strt_cnv), 0);
    chk({tag, ".done"},   32'(done), 0);
    chk({tag, ".chnnl"},  32'(chnnl), 0);
    chk({tag, ".accum"},  32'(accum), 0);
    chk({tag, ".pcomp"},  32'(pcomp), 0);
    chk({tag, ".error"},  32'(error), 0);
    chk({tag, ".intgrl"}, 32'(intgrl), 0);
    chk({tag, ".icomp"},  32'(icomp), 0);
    chk({tag, ".lft"},    32'(lft), 0);
    chk({tag, ".rht"},    32'(rht), 0);
  endtask

  task automatic run_cycle(input logic [11:0] a, input logic [11:0] b,
                           input logic signed [15:0] f, input bit glitch,
                           input int abort_at);
    int s0, lat, e, ic, pc, r1, l1, wt;
    bit early;
    s0 = n_strt;
    fwd = f;
    early = 0;
    if (glitch) begin
      cnv_cmplt = 1'b1; @(negedge clk); cnv_cmplt = 1'b0; @(negedge clk);
    end
    go = 1'b1; @(negedge clk); go = 1'b0;
    chk("cnvA.strt", 32'(strt_cnv), 1);
    chk("cnvA.chnnl", 32'(chnnl), 0);
    @(negedge clk);
    if (glitch) begin go = 1'b1; @(negedge clk); go = 1'b0; end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    a2d_res = a; cnv_cmplt = 1'b1;
    @(negedge clk); cnv_cmplt = glitch;
    chk("cnvB.strt", 32'(strt_cnv), 1);
    chk("cnvB.chnnl", 32'(chnnl), 1);
    chk("waitA.accum", 32'(accum), {20'h0, a});
    @(negedge clk); cnv_cmplt = 1'b0;
    wt = glitch ? 14 : int'($urandom_range(0, 3));
    repeat (wt) begin @(negedge clk); if (done) early = 1; end
    chk("waitB.hold", 32'(early), 0);
    a2d_res = b; cnv_cmplt = 1'b1;
    if (abort_at != 0) begin
      repeat (abort_at) begin @(negedge clk); cnv_cmplt = 1'b0; end
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      chk_all_zero("abort");
      lat = 0;
      repeat (20) begin @(negedge clk); if (done) lat = 1; end
      chk("abort.nodone", 32'(lat), 0);
      chk("abort.strtcnt", 32'(n_strt - s0), 2);
      m_int_dec = 0;
      m_intgrl = 0;
      return;
    end
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk); cnv_cmplt = 1'b0;
      if (done) lat = k;
    end
    chk("latency", 32'(lat), 11);
    @(negedge clk);
    chk("done.pulse", 32'(done), 0);
    chk("strt.count", 32'(n_strt - s0), 2);
    e = sat12(int'(a) - sx12(b));
    if (m_int_dec == 3) m_intgrl = sat12(m_intgrl + e);
    ic = (1280 * m_intgrl) >>> 12;
    pc = w16((e * 13952) >>> 12);
    r1 = w16(int'(f) - pc);
    l1 = w16(int'(f) + pc);
    chk("error",  32'(error),  e & 'hFFF);
    chk("intgrl", 32'(intgrl), m_intgrl & 'hFFF);
    chk("icomp",  32'(icomp),  ic & 'hFFF);
    chk("pcomp",  32'(pcomp),  pc & 'hFFFF);
    chk("rht",    32'(rht),    sat12(r1 - ic) & 'hFFF);
    chk("lft",    32'(lft),    sat12(l1 + ic) & 'hFFF);
    chk("accum",  32'(accum),  l1 & 'hFFFF);
    m_int_dec = (m_int_dec + 1) % 4;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; cnv_cmplt = 1'b0; a2d_res = '0; fwd = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset.src0", 32'(src0sel), 0);
    chk("reset.src1", 32'(src1sel), 0);
    chk("reset.ctl", 32'({multiply, sub, saturate}), 0);
    chk("iterm", 32'(iterm), 32'h500);
    chk("pterm", 32'(pterm), 32'h3680);
    rst_n = 1'b1;
    @(negedge clk);

    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("c1.error",  32'(error),  32'h100);
    chk("c1.pcomp",  32'(pcomp),  32'h0368);
    chk("c1.icomp",  32'(icomp),  32'h0);
    chk("c1.rht",    32'(rht),    32'hE98);
    chk("c1.lft",    32'(lft),    32'h568);
    chk("c1.intgrl", 32'(intgrl), 32'h0);
    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("c2.intgrl", 32'(intgrl), 32'h0);
    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("c3.intgrl", 32'(intgrl), 32'h0);
    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("c4.intgrl", 32'(intgrl), 32'h100);
    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("c5.icomp",  32'(icomp),  32'h050);

    run_cycle(12'hFFF, 12'h000, 16'sh0100, 0, 0);
    chk("sat.hi.error", 32'(error), 32'h7FF);
    run_cycle(12'h000, 12'hFFF, 16'sh0100, 0, 0);
    chk("sat.neg.error", 32'(error), 32'h001);

    run_cycle(12'($urandom), 12'($urandom), 16'($urandom_range(0, 1023)), 1, 0);
    for (int i = 0; i < 10; i++)
      run_cycle(12'($urandom), 12'($urandom), 16'($urandom_range(0, 1023)), 0, 0);

    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 5);
    run_cycle(12'h400, 12'h300, 16'sh0200, 0, 0);
    chk("post.error", 32'(error), 32'h100);
    chk("post.rht",   32'(rht),   32'hE98);
    chk("post.lft",   32'(lft),   32'h568);

    for (int i = 0; i < 6; i++)
      run_cycle(12'($urandom), 12'($urandom), 16'($urandom_range(0, 1023)),
                (i == 2), 0);
    chk("mult2_4.never", 32'(n_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
